// File: rtl/accfifo_drain_ctrl.sv
// ---------------------------------------------------------------------------
// accfifo_drain_ctrl
//
// Drain controller for one PE column's double-buffered accumulator FIFO pair.
// On every tile-complete pulse it swaps the compute/shadow FIFO select. It
// then reads drain_count words out of the shadow FIFO and packs them PACK at
// a time into wide beats. Each beat is written to the global buffer over a
// valid/ready interface, with the beat address incrementing from base_addr.
//
// Optional feature (compile-time macro ACCFIFO_DRAIN_RELU_EN):
//   defined   - words are signed; negative words are packed as zero (ReLU)
//   undefined - words are packed bit-exact
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   compute_done           1-cycle pulse: compute FIFO holds a finished tile
//   drain_count, base_addr word count / first beat address, taken with
//                          compute_done
//   which_fifo_to_compute  FIFO select to the ACCFIFO pair
//   shadow_fifo_read       read strobe; data arrives the following cycle
//   shadow_fifo_empty      shadow FIFO empty
//   shadow_fifo_data_out   shadow FIFO read data
//   gb_wvalid/gb_wready    global-buffer beat handshake
//   gb_wdata, gb_waddr     packed beat (word k at [k*DATA_WIDTH +: DATA_WIDTH])
//                          and its beat address
//   busy                   drain in progress
//   drain_done             1-cycle pulse after the last beat is accepted
//   overrun                sticky: a compute_done event was dropped
// ---------------------------------------------------------------------------
module accfifo_drain_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int NB_DATA    = 32,
  parameter int PACK       = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            compute_done,
  input  logic [$clog2(NB_DATA+1)-1:0]    drain_count,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  output logic                            which_fifo_to_compute,
  output logic                            shadow_fifo_read,
  input  logic                            shadow_fifo_empty,
  input  logic [DATA_WIDTH-1:0]           shadow_fifo_data_out,
  output logic                            gb_wvalid,
  input  logic                            gb_wready,
  output logic [PACK*DATA_WIDTH-1:0]      gb_wdata,
  output logic [ADDR_WIDTH-1:0]           gb_waddr,
  output logic                            busy,
  output logic                            drain_done,
  output logic                            overrun
);

  localparam int CNT_W  = $clog2(NB_DATA + 1);
  localparam int PCNT_W = $clog2(PACK + 1) + 1;
  localparam int BEAT_W = PACK * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    sel_q, sel_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    pend_q, pend_d;
  logic [CNT_W-1:0]        pend_cnt_q, pend_cnt_d;
  logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
  logic                    overrun_q, overrun_d;
  logic                    inflight_q, inflight_d;
  logic [PCNT_W-1:0]       pack_cnt_q, pack_cnt_d;
  logic [BEAT_W-1:0]       pack_q, pack_d;
  logic                    wvalid_q, wvalid_d;
  logic [BEAT_W-1:0]       wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;

  logic                    fifo_rd;
  logic [DATA_WIDTH-1:0]   word;
  logic [BEAT_W-1:0]       pack_cap;
  logic [PCNT_W-1:0]       cnt_cap;
  logic                    out_free;
  logic                    complete;
  logic                    flush;
  logic [CNT_W-1:0]        start_cnt;
  logic [ADDR_WIDTH-1:0]   start_addr;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case/if tree can leave one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    pend_d      = pend_q;
    pend_cnt_d  = pend_cnt_q;
    pend_addr_d = pend_addr_q;
    overrun_d   = overrun_q;
    inflight_d  = inflight_q;
    pack_cnt_d  = pack_cnt_q;
    pack_d      = pack_q;
    wvalid_d    = wvalid_q;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    fifo_rd     = 1'b0;
    complete    = 1'b0;
    flush       = 1'b0;
    start_cnt   = '0;
    start_addr  = '0;

    word = shadow_fifo_data_out;
`ifdef ACCFIFO_DRAIN_RELU_EN
    if (word[DATA_WIDTH-1]) word = '0;
`endif

    // Pack contents as they stand once this cycle's returning word lands.
    // Completion is judged on this view so a full pack leaves the same
    // cycle its last word arrives.
    pack_cap = pack_q;
    cnt_cap  = pack_cnt_q;
    if (inflight_q) begin
      for (int k = 0; k < PACK; k++) begin
        if (pack_cnt_q == PCNT_W'(k)) pack_cap[k*DATA_WIDTH +: DATA_WIDTH] = word;
      end
      cnt_cap = pack_cnt_q + PCNT_W'(1);
    end

    out_free = !wvalid_q || gb_wready;
    if (wvalid_q && gb_wready) wvalid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (compute_done || pend_q) begin
          start_cnt  = pend_q ? pend_cnt_q  : drain_count;
          start_addr = pend_q ? pend_addr_q : base_addr;
          sel_d      = !sel_q;
          rem_d      = start_cnt;
          addr_d     = start_addr;
          pend_d     = 1'b0;
          state_d    = (start_cnt == '0) ? DONE : DRAIN;
        end
      end

      DRAIN: begin
        // rem == 0 means no further reads can follow, so a partial pack is final.
        complete = (cnt_cap == PCNT_W'(PACK)) || ((rem_q == '0) && (cnt_cap != '0));
        flush    = complete && out_free;
        if (flush) begin
          wvalid_d   = 1'b1;
          wdata_d    = pack_cap;
          waddr_d    = addr_q;
          addr_d     = addr_q + ADDR_WIDTH'(1);
          pack_d     = '0;
          pack_cnt_d = '0;
        end else begin
          pack_d     = pack_cap;
          pack_cnt_d = cnt_cap;
        end

        // A flushing pack frees every lane, so reading keeps one word per cycle.
        fifo_rd = (rem_q != '0) && !shadow_fifo_empty &&
                  (flush || ((pack_cnt_q + PCNT_W'(inflight_q)) < PCNT_W'(PACK)));
        if (fifo_rd) rem_d = rem_q - CNT_W'(1);
        inflight_d = fifo_rd;

        if ((rem_q == '0) && !inflight_q && (pack_cnt_q == '0) && out_free) begin
          state_d = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A compute_done is served directly only from IDLE with nothing pending.
    // Otherwise it is held in the single pending slot; if that slot is
    // already occupied (and not being served this cycle), the event is lost.
    if (compute_done && !((state_q == IDLE) && !pend_q)) begin
      if (pend_q && (state_q != IDLE)) begin
        overrun_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_cnt_d  = drain_count;
        pend_addr_d = base_addr;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      rem_q       <= '0;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_cnt_q  <= '0;
      pend_addr_q <= '0;
      overrun_q   <= 1'b0;
      inflight_q  <= 1'b0;
      pack_cnt_q  <= '0;
      // NOTE: the pack and beat registers are cleared too; lanes of a partial
      // pack must read as zero, and they are only ever written word by word.
      pack_q      <= '0;
      wvalid_q    <= 1'b0;
      wdata_q     <= '0;
      waddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      pend_cnt_q  <= pend_cnt_d;
      pend_addr_q <= pend_addr_d;
      overrun_q   <= overrun_d;
      inflight_q  <= inflight_d;
      pack_cnt_q  <= pack_cnt_d;
      pack_q      <= pack_d;
      wvalid_q    <= wvalid_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
    end
  end

  assign which_fifo_to_compute = sel_q;
  assign shadow_fifo_read      = fifo_rd;
  assign gb_wvalid             = wvalid_q;
  assign gb_wdata              = wdata_q;
  assign gb_waddr              = waddr_q;
  assign busy                  = (state_q == DRAIN);
  assign drain_done            = (state_q == DONE);
  assign overrun               = overrun_q;

endmodule

// File: tb/tb_accfifo_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_accfifo_drain_ctrl
//
// Directed bench for accfifo_drain_ctrl with default parameters
// (DATA_WIDTH=24, NB_DATA=32, PACK=4, ADDR_WIDTH=10). A small shadow FIFO
// model answers read strobes one cycle later. A posedge monitor records
// accepted beats, read strobes and drain_done pulses. Inputs are driven and
// outputs sampled on the falling edge. The ReLU expectation follows the
// ACCFIFO_DRAIN_RELU_EN macro.
// ---------------------------------------------------------------------------
module tb_accfifo_drain_ctrl;

  localparam int DW   = 24;
  localparam int NB   = 32;
  localparam int PACK = 4;
  localparam int AW   = 10;
  localparam int CW   = $clog2(NB + 1);
  localparam int BW   = PACK * DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            compute_done = 1'b0;
  logic [CW-1:0]   drain_count = '0;
  logic [AW-1:0]   base_addr = '0;
  logic            which_fifo_to_compute;
  logic            shadow_fifo_read;
  logic            shadow_fifo_empty;
  logic [DW-1:0]   shadow_fifo_data_out = '0;
  logic            gb_wvalid;
  logic            gb_wready = 1'b1;
  logic [BW-1:0]   gb_wdata;
  logic [AW-1:0]   gb_waddr;
  logic            busy;
  logic            drain_done;
  logic            overrun;

  accfifo_drain_ctrl #(
    .DATA_WIDTH(DW), .NB_DATA(NB), .PACK(PACK), .ADDR_WIDTH(AW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .compute_done          (compute_done),
    .drain_count           (drain_count),
    .base_addr             (base_addr),
    .which_fifo_to_compute (which_fifo_to_compute),
    .shadow_fifo_read      (shadow_fifo_read),
    .shadow_fifo_empty     (shadow_fifo_empty),
    .shadow_fifo_data_out  (shadow_fifo_data_out),
    .gb_wvalid             (gb_wvalid),
    .gb_wready             (gb_wready),
    .gb_wdata              (gb_wdata),
    .gb_waddr              (gb_waddr),
    .busy                  (busy),
    .drain_done            (drain_done),
    .overrun               (overrun)
  );

  always #5 clk = ~clk;

  // Shadow FIFO model: written by the stimulus, read by the DUT strobe.
  logic [DW-1:0] mem [0:255];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          fifo_flush = 1'b0;
  logic          empty_mask = 1'b0;

  assign shadow_fifo_empty = empty_mask || (wr_ptr == rd_ptr);

  typedef struct {
    logic [BW-1:0] data;
    logic [AW-1:0] addr;
  } beat_t;

  beat_t beats[$];
  int    reads_total = 0;
  int    done_total  = 0;
  int    rd_empty    = 0;

  always @(posedge clk) begin
    if (shadow_fifo_read) shadow_fifo_data_out <= mem[rd_ptr[7:0]];
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (shadow_fifo_read) rd_ptr <= rd_ptr + 1;
    if (shadow_fifo_read) reads_total <= reads_total + 1;
    if (shadow_fifo_read && shadow_fifo_empty) rd_empty <= rd_empty + 1;
    if (drain_done) done_total <= done_total + 1;
    if (gb_wvalid && gb_wready) beats.push_back('{data: gb_wdata, addr: gb_waddr});
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  // Pulse compute_done for one cycle; returns in the cycle after the pulse.
  task automatic start_drain(input int cnt, input logic [AW-1:0] addr);
    compute_done = 1'b1;
    drain_count  = CW'(cnt);
    base_addr    = addr;
    tick();
    compute_done = 1'b0;
  endtask

  // Wait (bounded) for one drain_done, then confirm it pulsed exactly once.
  task automatic wait_done(input string tag);
    int base;
    int n;
    base = done_total;
    n = 0;
    while (done_total == base && n < 200) begin
      tick();
      n++;
    end
    tick();
    tick();
    check(tag, done_total - base, 1);
  endtask

  logic [BW-1:0] d0;
  logic [AW-1:0] a0;
  logic          stable;
  logic          exp_sel;
  int            rb;
  int            bb;
  int            n;
  int            stall_reads;

  initial begin
    exp_sel = 1'b0;

    // Reset: every output low.
    rst = 1'b1;
    tick(); tick(); tick();
    check("reset_outputs",
          {which_fifo_to_compute, shadow_fifo_read, gb_wvalid, gb_wdata, gb_waddr,
           busy, drain_done, overrun}, '0);
    rst = 1'b0;
    tick();

    // 1: eight words 1..8 from 0x3FE with gb_wready high.
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    rb = reads_total; bb = beats.size();
    start_drain(8, 10'h3FE);
    exp_sel = ~exp_sel;
    check("t1_sel_toggle", which_fifo_to_compute, exp_sel);
    check("t1_first_read", shadow_fifo_read, 1'b1);
    check("t1_busy", busy, 1'b1);
    for (int k = 2; k <= 6; k++) begin
      tick();
      if (k == 5) check("t1_wvalid_T5", gb_wvalid, 1'b0);
      if (k == 6) check("t1_wvalid_T6", gb_wvalid, 1'b1);
    end
    wait_done("t1_drain_done_once");
    check("t1_beat_count", beats.size() - bb, 2);
    check("t1_beat0_data", beats[bb].data, {24'd4, 24'd3, 24'd2, 24'd1});
    check("t1_beat0_addr", beats[bb].addr, 10'h3FE);
    check("t1_beat1_data", beats[bb+1].data, {24'd8, 24'd7, 24'd6, 24'd5});
    check("t1_beat1_addr", beats[bb+1].addr, 10'h3FF);
    check("t1_reads", reads_total - rb, 8);
    check("t1_idle", {busy, gb_wvalid}, 2'b00);

    // 2: five of six words, base 0x3FF so the second beat wraps to 0.
    for (int i = 10; i <= 15; i++) push_word(DW'(i));
    rb = reads_total; bb = beats.size();
    start_drain(5, 10'h3FF);
    exp_sel = ~exp_sel;
    check("t2_sel_toggle", which_fifo_to_compute, exp_sel);
    wait_done("t2_drain_done_once");
    check("t2_beat_count", beats.size() - bb, 2);
    check("t2_beat0_data", beats[bb].data, {24'd13, 24'd12, 24'd11, 24'd10});
    check("t2_beat0_addr", beats[bb].addr, 10'h3FF);
    check("t2_beat1_data", beats[bb+1].data, {24'd0, 24'd0, 24'd0, 24'd14});
    check("t2_beat1_addr", beats[bb+1].addr, 10'h000);
    check("t2_reads", reads_total - rb, 5);
    check("t2_fifo_left", wr_ptr - rd_ptr, 1);
    fifo_flush = 1'b1;
    tick();
    fifo_flush = 1'b0;
    tick();

    // 3: back-pressure on the first beat for ten cycles.
    for (int i = 0; i < 8; i++) push_word(DW'(24'h100 + i));
    gb_wready = 1'b0;
    rb = reads_total; bb = beats.size();
    start_drain(8, 10'h200);
    exp_sel = ~exp_sel;
    n = 0;
    while (!gb_wvalid && n < 20) begin
      tick();
      n++;
    end
    check("t3_wvalid_seen", gb_wvalid, 1'b1);
    d0 = gb_wdata;
    a0 = gb_waddr;
    stable = 1'b1;
    stall_reads = 0;
    for (int i = 0; i < 10; i++) begin
      if (shadow_fifo_read) stall_reads++;
      if (!(gb_wvalid && gb_wdata == d0 && gb_waddr == a0)) stable = 1'b0;
      tick();
    end
    check("t3_stable_under_stall", stable, 1'b1);
    check("t3_stall_reads_le3", stall_reads <= 3, 1'b1);
    check("t3_stalled_data", d0, {24'h103, 24'h102, 24'h101, 24'h100});
    check("t3_stalled_addr", a0, 10'h200);
    gb_wready = 1'b1;
    wait_done("t3_drain_done_once");
    check("t3_beat_count", beats.size() - bb, 2);
    check("t3_beat1_data", beats[bb+1].data, {24'h107, 24'h106, 24'h105, 24'h104});
    check("t3_beat1_addr", beats[bb+1].addr, 10'h201);
    check("t3_reads", reads_total - rb, 8);

    // 4: shadow FIFO flags empty every other cycle.
    for (int i = 0; i < 4; i++) push_word(DW'(24'h20 + i));
    rb = reads_total; bb = beats.size();
    n = rd_empty;
    empty_mask = 1'b1;
    start_drain(4, 10'h080);
    exp_sel = ~exp_sel;
    stall_reads = 0;
    while (done_total == 0 + done_total && busy && stall_reads < 100) begin
      empty_mask = ~empty_mask;
      tick();
      stall_reads++;
    end
    empty_mask = 1'b0;
    tick(); tick();
    check("t4_no_read_when_empty", rd_empty - n, 0);
    check("t4_beat_count", beats.size() - bb, 1);
    check("t4_beat0_data", beats[bb].data, {24'h23, 24'h22, 24'h21, 24'h20});
    check("t4_reads", reads_total - rb, 4);

    // 5: second compute_done pends, third sets overrun.
    for (int i = 1; i <= 4; i++) push_word(DW'(24'h30 + i));
    start_drain(4, 10'h040);
    exp_sel = ~exp_sel;
    tick();
    start_drain(0, 10'h055);
    check("t5_no_overrun_on_pend", overrun, 1'b0);
    check("t5_busy_while_pend", busy, 1'b1);
    start_drain(0, 10'h066);
    check("t5_overrun_set", overrun, 1'b1);
    n = 0;
    while (!drain_done && n < 50) begin
      tick();
      n++;
    end
    check("t5_first_done", drain_done, 1'b1);
    check("t5_sel_at_done", which_fifo_to_compute, exp_sel);
    tick();
    check("t5_sel_idle_cycle", which_fifo_to_compute, exp_sel);
    tick();
    exp_sel = ~exp_sel;
    check("t5_second_swap", which_fifo_to_compute, exp_sel);
    check("t5_second_done", drain_done, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("t5_no_third_swap", which_fifo_to_compute, exp_sel);
    check("t5_overrun_sticky", overrun, 1'b1);

    // Reset clears the sticky overrun and the select.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst2_clears", {overrun, which_fifo_to_compute}, 2'b00);
    exp_sel = 1'b0;

    // 6: signed words {-5, 7, -1, 0}.
    push_word(24'hFFFFFB);
    push_word(24'h000007);
    push_word(24'hFFFFFF);
    push_word(24'h000000);
    bb = beats.size();
    start_drain(4, 10'h100);
    wait_done("t6_drain_done_once");
    check("t6_beat_count", beats.size() - bb, 1);
`ifdef ACCFIFO_DRAIN_RELU_EN
    check("t6_relu_beat", beats[bb].data, {24'h000000, 24'h000000, 24'h000007, 24'h000000});
`else
    check("t6_raw_beat", beats[bb].data, {24'h000000, 24'hFFFFFF, 24'h000007, 24'hFFFFFB});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/accfifo_drain_ctrl.md
Name: accfifo_drain_ctrl

Overview:
- Downstream consumer of the double-buffered accumulator FIFO pair. Owns the `which_fifo_to_compute` select.
- On each tile-complete pulse it swaps the compute and shadow FIFOs, then drains the shadow FIFO.
- Drained words are packed PACK at a time into wide beats and written to the global buffer over a valid/ready interface with an incrementing address.
- One instance per PE column, between the column's ACCFIFO pair and the global-buffer write arbiter.

Parameters:
- DATA_WIDTH, 24, width of one accumulator word (matches ACCFIFO output_width)
- NB_DATA, 32, ACCFIFO depth; maximum words per drain
- PACK, 4, words per global-buffer beat (1..8)
- ADDR_WIDTH, 10, global-buffer beat address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- compute_done  in  1  one-cycle pulse: compute FIFO holds a finished tile
- drain_count  in  $clog2(NB_DATA+1)  words to drain; sampled with compute_done
- base_addr  in  ADDR_WIDTH  first beat address; sampled with compute_done
- which_fifo_to_compute  out  1  FIFO select to the ACCFIFO pair
- shadow_fifo_read  out  1  read strobe to the shadow FIFO
- shadow_fifo_empty  in  1  shadow FIFO empty
- shadow_fifo_data_out  in  DATA_WIDTH  shadow FIFO data; valid the cycle after the read strobe
- gb_wvalid  out  1  beat valid
- gb_wready  in  1  global buffer accepts beat
- gb_wdata  out  PACK*DATA_WIDTH  packed beat; word k in bits [k*DATA_WIDTH +: DATA_WIDTH]
- gb_waddr  out  ADDR_WIDTH  beat address
- busy  out  1  drain in progress
- drain_done  out  1  one-cycle pulse when the last beat is accepted
- overrun  out  1  sticky: compute_done lost

Behaviour:
- Reset values: all outputs 0. Internal state, counters, pack register and pending flag are cleared. Reset mid-drain abandons the drain; FIFO contents are left untouched.

State machine:
- IDLE
  - On compute_done, or a pending flag set on entry: toggle which_fifo_to_compute (registered, visible next cycle).
  - Latch drain_count into rem and base_addr into addr; clear pending.
  - If drain_count == 0: go to DONE. Otherwise go to DRAIN.
- DRAIN: busy = 1.
  - shadow_fifo_read = (rem > 0) && !shadow_fifo_empty && (pack_cnt + inflight < PACK). inflight is at most one.
  - Each read decrements rem. The returned word lands in lane pack_cnt, and pack_cnt increments.
  - Pack completes when pack_cnt == PACK, or when rem == 0 with no read in flight and pack_cnt > 0. Unused lanes are zero.
  - A complete pack moves to the output register when !gb_wvalid || gb_wready, then pack_cnt resets to 0. Reads resume the same cycle.
  - gb_wvalid, gb_wdata and gb_waddr stay stable while gb_wvalid && !gb_wready.
  - addr increments by 1 per accepted beat and wraps modulo 2^ADDR_WIDTH.
  - After the final beat is accepted (rem == 0, pack empty, output accepted): go to DONE.
- DONE: drain_done = 1 for one cycle, busy = 0, go to IDLE.

Timing and corner cases:
- Latency: compute_done at cycle T gives the select toggle at T+1 and the first read at T+1 if the shadow FIFO is non-empty. With PACK = 4 and gb_wready held high, first gb_wvalid is at T+6.
- Throughput is one word per cycle when the FIFO is non-empty.
- shadow_fifo_empty with rem > 0: wait with no read. An empty FIFO never causes a read.
- compute_done while not in IDLE sets pending; it is served on return to IDLE (one cycle in IDLE before the swap).
- compute_done while pending is already set: set overrun, pending stays set, the event is dropped. overrun clears only on rst.
- compute_done in the same cycle as DONE counts as busy, so it is pended.

Optional Feature:
- Macro ACCFIFO_DRAIN_RELU_EN.
- Defined: each word is treated as signed two's complement. Negative words are written as zero when packed; non-negative words pass unchanged. Timing is unchanged.
- Undefined: words are packed bit-exact.

Test Plan:
- Reset, then compute_done with drain_count = 8, base_addr = 0x3FE; FIFO preloaded 1..8; gb_wready = 1 → select toggles 0→1; two beats, {4,3,2,1} at 0x3FE and {8,7,6,5} at 0x3FF; drain_done once; exactly 8 reads.
- drain_count = 5 (values 10..14) → beats {13,12,11,10} and {0,0,0,14}; 5 reads, never 6.
- gb_wready low for 10 cycles during the first beat → gb_wdata and gb_waddr stable; no more than 3 extra reads issued; no data lost.
- shadow_fifo_empty toggles every other cycle, drain_count = 4 → reads only when not empty; one correct beat.
- Second compute_done mid-drain → second swap one cycle after drain_done. A third compute_done before that → overrun = 1 and stays 1.
- With ACCFIFO_DRAIN_RELU_EN defined, words {-5, 7, -1, 0} → beat {0, 0, 7, 0}. Without it → raw values.
